mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.
REQ-004 The block SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W and cpu_wdata in DATA_W, carrying the processor request.
REQ-007 The block SHALL have ports cpu_rdata out DATA_W and cpu_ack out 1, carrying the processor response.
REQ-008 The block SHALL have ports ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata and ldr_ack, with the same widths and meanings as the cpu_* ports, for the program loader.
REQ-009 The block SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W and mem_rdata in DATA_W, forming the single-port unified memory interface.
REQ-010 The block SHALL have port busy out 1, high when a transaction is in flight.
REQ-011 The block SHALL have port owner out 1, identifying the current transaction owner: 0 = cpu, 1 = ldr.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and DONE.
REQ-013 In IDLE, if no request is pending, the FSM SHALL remain in IDLE.
REQ-014 In IDLE, with exactly one request pending, the arbiter SHALL grant that requester.
REQ-015 In IDLE, with both requests pending, the arbiter SHALL grant the requester other than last_owner (round-robin).
REQ-016 On a grant, the block SHALL latch the winner's we, addr and wdata and its identity into owner, update last_owner, and go to ISSUE.
REQ-017 ISSUE SHALL last 1 cycle: mem_en = 1 and mem_we = latched we; the FSM then goes to WAIT with the latency counter loaded to MEM_LAT.
REQ-018 WAIT SHALL last exactly MEM_LAT cycles; on its last cycle, for a read, the block SHALL capture mem_rdata into the owner's rdata register.
REQ-019 DONE SHALL last 1 cycle: the owner's ack = 1; the FSM then returns to IDLE.
REQ-020 Timing: with req sampled high in IDLE cycle N, mem_en SHALL be high in cycle N+1 and ack SHALL be high in cycle N+MEM_LAT+2, identically for reads and writes.
REQ-021 mem_addr, mem_wdata and owner SHALL be held stable from ISSUE through DONE.
REQ-022 mem_en and mem_we SHALL be 0 in every state except ISSUE.
REQ-023 busy SHALL be 1 in ISSUE, WAIT and DONE, and 0 in IDLE.
REQ-024 Requests SHALL be sampled only in IDLE; req activity in ISSUE, WAIT and DONE SHALL be ignored.
REQ-025 A req still high in the IDLE cycle after its ack SHALL be treated as a new transaction.
REQ-026 A req dropped mid-transaction SHALL NOT abort that transaction; ack SHALL still pulse.
REQ-027 cpu_rdata and ldr_rdata SHALL be registered: each holds its last captured read value until the next read by the same port completes, and writes SHALL leave it unchanged.
REQ-028 The non-owner's ack SHALL stay 0, and its rdata SHALL be unchanged, for the whole transaction.
REQ-029 The block SHALL be back-to-back capable: if both requesters hold req continuously, grants SHALL alternate cpu, ldr, cpu, ..., with one IDLE cycle between transactions.
REQ-030 The latency counter SHALL be 3 bits wide; MEM_LAT = 0 or MEM_LAT > 7 is unsupported.

Reset
REQ-031 While reset = 0, the block SHALL immediately force: FSM = IDLE, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_ack = 0, ldr_ack = 0, cpu_rdata = 0, ldr_rdata = 0, busy = 0, owner = 0, last_owner = 1 (so the cpu wins the first tie).
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no ack; after release, arbitration SHALL resume from IDLE on the next clk edge.

Verification
REQ-033 The bench SHALL cover: MEM_LAT=1, single cpu read of addr 0x10, memory returns 0xDEADBEEF -> mem_en in cycle N+1, cpu_ack in cycle N+3, cpu_rdata=0xDEADBEEF, ldr_ack never high.
REQ-034 The bench SHALL cover: cpu_req and ldr_req both high from reset release, held -> grants cpu, ldr, cpu, ldr; each ack exactly one cycle; owner matches each ack.
REQ-035 The bench SHALL cover: ldr write 0x0000_0013 to 0x0 with MEM_LAT=3 -> mem_en=1 and mem_we=1 for one cycle, addr and data stable until ldr_ack in cycle N+5, ldr_rdata unchanged.
REQ-036 The bench SHALL cover: reset pulled low during WAIT -> all outputs 0 asynchronously, no ack; after release, a pending cpu_req is served with normal latency.
REQ-037 The bench SHALL cover: cpu_req dropped during WAIT -> cpu_ack still pulses, and no second transaction follows.
REQ-038 The bench SHALL cover: cpu_req held high across its ack -> a second cpu transaction starts in the next IDLE cycle, with one idle cycle between the two mem_en pulses' transactions.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving a cpu port and a program-loader port
// shared access to one single-port memory with a fixed read latency.
//
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata  processor request
//   cpu_rdata, cpu_ack     processor response; rdata holds the last read value
//   ldr_*                  the same set of ports for the program loader
//   mem_en/we/addr/wdata   memory command; mem_en pulses for one cycle per access
//   mem_rdata              memory read data, valid MEM_LAT cycles after mem_en
//   busy                   a transaction is in flight (ISSUE, WAIT or DONE)
//   owner                  current transaction owner: 0 = cpu, 1 = ldr
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              we_q, we_d;
    logic              last_owner, last_owner_d;
    logic              owner_d;
    logic              grant;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_d, ldr_rdata_d;
    logic              mem_en_d, mem_we_d, busy_d, cpu_ack_d, ldr_ack_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            last_owner <= 1'b1;   // cpu wins the first tie
            owner      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            we_q       <= we_d;
            last_owner <= last_owner_d;
            owner      <= owner_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_rdata  <= cpu_rdata_d;
            ldr_rdata  <= ldr_rdata_d;
            cpu_ack    <= cpu_ack_d;
            ldr_ack    <= ldr_ack_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        we_d         = we_q;
        last_owner_d = last_owner;
        owner_d      = owner;
        grant        = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        cpu_rdata_d  = cpu_rdata;
        ldr_rdata_d  = ldr_rdata;

        case (state)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    // On a tie the requester that did not go last wins
                    grant        = (cpu_req && ldr_req) ? ~last_owner : ldr_req;
                    owner_d      = grant;
                    last_owner_d = grant;
                    we_d         = grant ? ldr_we    : cpu_we;
                    mem_addr_d   = grant ? ldr_addr  : cpu_addr;
                    mem_wdata_d  = grant ? ldr_wdata : cpu_wdata;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner) ldr_rdata_d = mem_rdata;
                        else       cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it
        mem_en_d  = (state_d == ISSUE);
        mem_we_d  = (state_d == ISSUE) && we_d;
        busy_d    = (state_d != IDLE);
        cpu_ack_d = (state_d == DONE) && !owner_d;
        ldr_ack_d = (state_d == DONE) &&  owner_d;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=3
// instances sharing one set of requester inputs, each with its own memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

    logic [31:0] cpu_rdata_1, ldr_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        cpu_ack_1, ldr_ack_1, mem_en_1, mem_we_1, busy_1, owner_1;
    logic [31:0] cpu_rdata_3, ldr_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic        cpu_ack_3, ldr_ack_3, mem_en_3, mem_we_3, busy_3, owner_3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_1), .cpu_ack(cpu_ack_1),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata_1), .ldr_ack(ldr_ack_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1), .owner(owner_1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_3), .cpu_ack(cpu_ack_3),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata_3), .ldr_ack(ldr_ack_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .busy(busy_3), .owner(owner_3)
    );

    // Memory contents: 0x10 holds 0xDEADBEEF, every other address reads 0x1000_0000 | addr
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (32'h1000_0000 | a);
    endfunction

    // Read pipelines: data is driven only in the cycle it is valid, garbage otherwise
    logic [32:0] p1;
    logic [32:0] p3 [3];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1    <= '0;
            p3[0] <= '0;
            p3[1] <= '0;
            p3[2] <= '0;
        end else begin
            p1    <= {mem_en_1 && !mem_we_1, rd_val(mem_addr_1)};
            p3[0] <= {mem_en_3 && !mem_we_3, rd_val(mem_addr_3)};
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign mem_rdata_1 = p1[32]    ? p1[31:0]    : 32'hBAD0_BAD0;
    assign mem_rdata_3 = p3[2][32] ? p3[2][31:0] : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_mem_en",    32'(mem_en_1), 32'd0);
        chk("rst_mem_we",    32'(mem_we_1), 32'd0);
        chk("rst_busy",      32'(busy_1),   32'd0);
        chk("rst_owner",     32'(owner_1),  32'd0);
        chk("rst_cpu_ack",   32'(cpu_ack_1), 32'd0);
        chk("rst_ldr_ack",   32'(ldr_ack_1), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata_1, 32'd0);
        chk("rst_ldr_rdata", ldr_rdata_1, 32'd0);
        chk("rst_mem_addr",  mem_addr_1,  32'd0);
        chk("rst_busy3",     32'(busy_3),   32'd0);

        // Both requesting from reset release: cpu, ldr, cpu, ldr on the MEM_LAT=1 instance
        cpu_req = 1'b1; cpu_addr = 32'h20;
        ldr_req = 1'b1; ldr_addr = 32'h30;
        reset   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("rr_cpu_ack_%0d", k), 32'(cpu_ack_1), 32'((k == 3) || (k == 11)));
            chk($sformatf("rr_ldr_ack_%0d", k), 32'(ldr_ack_1), 32'((k == 7) || (k == 15)));
            chk($sformatf("rr_mem_en_%0d", k),  32'(mem_en_1),  32'(k % 4 == 1));
            if (k % 4 == 3)
                chk($sformatf("rr_owner_%0d", k), 32'(owner_1), 32'((k == 7) || (k == 15)));
            if (k % 4 == 1)
                chk($sformatf("rr_addr_%0d", k), mem_addr_1, (k % 8 == 1) ? 32'h20 : 32'h30);
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (4) tick();
        chk("rr_cpu_rdata", cpu_rdata_1, 32'h1000_0020);
        chk("rr_ldr_rdata", ldr_rdata_1, 32'h1000_0030);
        chk("rr_idle1", 32'(busy_1), 32'd0);
        chk("rr_idle3", 32'(busy_3), 32'd0);

        // Single cpu read of 0x10, MEM_LAT=1 (and MEM_LAT=3 alongside)
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();                                                  // N+1
        cpu_req = 1'b0;
        chk("rd_mem_en",   32'(mem_en_1), 32'd1);
        chk("rd_mem_we",   32'(mem_we_1), 32'd0);
        chk("rd_addr",     mem_addr_1, 32'h10);
        chk("rd_busy",     32'(busy_1), 32'd1);
        chk("rd_mem_en3",  32'(mem_en_3), 32'd1);
        tick();                                                  // N+2
        chk("rd_en_off",   32'(mem_en_1), 32'd0);
        chk("rd_ack_early", 32'(cpu_ack_1), 32'd0);
        chk("rd_ldr_ack2", 32'(ldr_ack_1), 32'd0);
        tick();                                                  // N+3
        chk("rd_ack",      32'(cpu_ack_1), 32'd1);
        chk("rd_rdata",    cpu_rdata_1, 32'hDEAD_BEEF);
        chk("rd_ldr_ack3", 32'(ldr_ack_1), 32'd0);
        chk("rd_ldr_keep", ldr_rdata_1, 32'h1000_0030);
        tick();                                                  // N+4
        chk("rd_ack_off",  32'(cpu_ack_1), 32'd0);
        chk("rd_idle",     32'(busy_1), 32'd0);
        chk("rd_ack3_early", 32'(cpu_ack_3), 32'd0);
        tick();                                                  // N+5
        chk("rd_ack3",     32'(cpu_ack_3), 32'd1);
        chk("rd_rdata3",   cpu_rdata_3, 32'hDEAD_BEEF);
        tick();
        chk("rd_idle3",    32'(busy_3), 32'd0);

        // Loader write 0x13 to 0x0, MEM_LAT=3
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h0; ldr_wdata = 32'h13;
        tick();                                                  // N+1
        ldr_req = 1'b0;
        chk("wr_mem_en", 32'(mem_en_3), 32'd1);
        chk("wr_mem_we", 32'(mem_we_3), 32'd1);
        chk("wr_owner",  32'(owner_3),  32'd1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("wr_en_%0d", c),   32'(mem_en_3), 32'd0);
            chk($sformatf("wr_we_%0d", c),   32'(mem_we_3), 32'd0);
            chk($sformatf("wr_addr_%0d", c), mem_addr_3, 32'h0);
            chk($sformatf("wr_data_%0d", c), mem_wdata_3, 32'h13);
            chk($sformatf("wr_ack_%0d", c),  32'(ldr_ack_3), 32'(c == 5));
            chk($sformatf("wr_cack_%0d", c), 32'(cpu_ack_3), 32'd0);
        end
        chk("wr_ldr_rdata", ldr_rdata_3, 32'h1000_0030);
        tick();
        chk("wr_idle", 32'(busy_3), 32'd0);
        ldr_we = 1'b0;

        // Reset during WAIT abandons the transaction; pending cpu_req served afterwards
        cpu_req = 1'b1; cpu_addr = 32'h44;
        tick(); tick();                                          // N+2, WAIT
        chk("ra_busy_pre", 32'(busy_3), 32'd1);
        reset = 1'b0;
        #1;
        chk("ra_busy",     32'(busy_3), 32'd0);
        chk("ra_mem_en",   32'(mem_en_3), 32'd0);
        chk("ra_mem_addr", mem_addr_3, 32'd0);
        chk("ra_owner",    32'(owner_3), 32'd0);
        chk("ra_cpu_rd",   cpu_rdata_3, 32'd0);
        chk("ra_ldr_rd",   ldr_rdata_3, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ra_no_ack_%0d", c), 32'(cpu_ack_3), 32'd0);
        end
        reset = 1'b1;                                            // cycle M, IDLE
        tick();                                                  // M+1
        cpu_req = 1'b0;
        chk("ra_en_after",   32'(mem_en_3), 32'd1);
        chk("ra_addr_after", mem_addr_3, 32'h44);
        tick(); tick(); tick();                                  // M+4
        chk("ra_ack_early", 32'(cpu_ack_3), 32'd0);
        tick();                                                  // M+5
        chk("ra_ack",   32'(cpu_ack_3), 32'd1);
        chk("ra_rdata", cpu_rdata_3, 32'h1000_0044);
        tick();

        // cpu_req dropped during WAIT: ack still pulses, no follow-on transaction
        cpu_req = 1'b1; cpu_addr = 32'h50;
        tick(); tick();                                          // N+2
        cpu_req = 1'b0;
        tick();                                                  // N+3
        chk("dr_ack1", 32'(cpu_ack_1), 32'd1);
        tick(); tick();                                          // N+5
        chk("dr_ack3",   32'(cpu_ack_3), 32'd1);
        chk("dr_rdata3", cpu_rdata_3, 32'h1000_0050);
        for (int c = 6; c <= 9; c++) begin
            tick();
            chk($sformatf("dr_quiet_en_%0d", c),   32'(mem_en_3), 32'd0);
            chk($sformatf("dr_quiet_busy_%0d", c), 32'(busy_3), 32'd0);
            chk($sformatf("dr_quiet_en1_%0d", c),  32'(mem_en_1), 32'd0);
        end

        // cpu_req held across its ack: a second transaction after one idle cycle
        cpu_req = 1'b1; cpu_addr = 32'h60;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("bb_en_%0d", c),   32'(mem_en_1), 32'((c == 1) || (c == 5)));
            chk($sformatf("bb_ack_%0d", c),  32'(cpu_ack_1), 32'((c == 3) || (c == 7)));
            chk($sformatf("bb_busy_%0d", c), 32'(busy_1), 32'(c != 4));
            if (c == 5) cpu_req = 1'b0;
        end
        repeat (3) tick();
        chk("bb_rdata", cpu_rdata_1, 32'h1000_0060);
        chk("bb_idle1", 32'(busy_1), 32'd0);
        chk("bb_idle3", 32'(busy_3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
